// File: rtl/y86_seq_frontend.sv
// Y86-64 sequential front end: registered fetch feeding combinational decode/execute and a condition-code register.
// Latency: fetch fields 1 clk after PC; decode/execute combinational; CC updates 1 clk after an OPq is fetched.
// Backpressure: none; a new PC is fetched on every rising edge.
module y86_seq_frontend #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] PC,
    input  logic        imem_we,
    input  logic [9:0]  imem_addr,
    input  logic [7:0]  imem_wdata,
    input  logic        rf_we,
    input  logic [3:0]  rf_waddr,
    input  logic [63:0] rf_wdata,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        in_mem,
    output logic        in_inst,
    output logic        hlt,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] valE,
    output logic        cond,
    output logic        ZF,
    output logic        SF,
    output logic        OF
);
    localparam int          AW      = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [64:0] MEM_LIM = 65'(IMEM_BYTES);
    localparam logic [3:0]  RNONE   = 4'hF;
    localparam logic [3:0]  RSP     = 4'h4;

    // Instruction memory: no reset, contents survive rst_n
    logic [7:0] imem [IMEM_BYTES];

    always_ff @(posedge clk) begin
        if (imem_we && ({55'b0, imem_addr} < MEM_LIM))
            imem[AW'(imem_addr)] <= imem_wdata;
    end

    // Ten bytes starting at PC; bytes past the end of memory read as zero
    logic [7:0]  ib    [10];
    logic [64:0] baddr [10];

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            baddr[i] = {1'b0, PC} + 65'(i);
            ib[i]    = (baddr[i] < MEM_LIM) ? imem[AW'(baddr[i])] : 8'h00;
        end
    end

    logic [3:0]  f_icode, f_ifun, f_ra, f_rb, f_len;
    logic        f_regs, f_inst, f_mem, f_err;
    logic [63:0] f_valc, f_valp;
    logic [64:0] f_last;

    always_comb begin
        f_icode = ib[0][7:4];
        f_ifun  = ib[0][3:0];
        f_len   = 4'd1;
        f_regs  = 1'b0;
        f_valc  = '0;
        case (f_icode)
            4'h2, 4'h6, 4'hA, 4'hB: begin
                f_len  = 4'd2;
                f_regs = 1'b1;
            end
            4'h7, 4'h8: begin
                f_len  = 4'd9;
                f_valc = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
            end
            4'h3, 4'h4, 4'h5: begin
                f_len  = 4'd10;
                f_regs = 1'b1;
                f_valc = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
            end
            default: ;
        endcase
        f_ra   = f_regs ? ib[1][7:4] : RNONE;
        f_rb   = f_regs ? ib[1][3:0] : RNONE;
        f_inst = (f_icode > 4'hB)
               || ((f_ifun != 4'h0) && !(f_icode inside {4'h2, 4'h6, 4'h7}))
               || ((f_icode inside {4'h2, 4'h7}) && (f_ifun > 4'h6))
               || ((f_icode == 4'h6) && (f_ifun > 4'h3));
        // 65-bit end address so a PC near 2^64 still reports a memory error
        f_last = {1'b0, PC} + 65'(f_len) - 65'd1;
        f_mem  = (f_last >= MEM_LIM);
        f_err  = f_inst | f_mem;
        f_valp = f_err ? PC : PC + 64'(f_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode   <= '0;
            ifun    <= '0;
            rA      <= RNONE;
            rB      <= RNONE;
            valC    <= '0;
            valP    <= '0;
            in_mem  <= 1'b0;
            in_inst <= 1'b0;
            hlt     <= 1'b0;
        end else begin
            icode   <= f_icode;
            ifun    <= f_ifun;
            rA      <= f_ra;
            rB      <= f_rb;
            valC    <= f_valc;
            valP    <= f_valp;
            in_mem  <= f_mem;
            in_inst <= f_inst;
            hlt     <= (f_icode == 4'h0) && !f_err;
        end
    end

    logic [63:0] rf [15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) rf[i] <= '0;
        end else if (rf_we && (rf_waddr != RNONE)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    logic [3:0] src_a, src_b;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        case (icode)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = rA;
            4'h9, 4'hB:             src_a = RSP;
            default: ;
        endcase
        case (icode)
            4'h4, 4'h5, 4'h6:       src_b = rB;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
            default: ;
        endcase
        valA = (src_a == RNONE) ? 64'd0 : rf[src_a];
        valB = (src_b == RNONE) ? 64'd0 : rf[src_b];
    end

    logic of_next;

    always_comb begin
        valE    = '0;
        of_next = 1'b0;
        case (icode)
            4'h2:       valE = valA;
            4'h3:       valE = valC;
            4'h4, 4'h5: valE = valB + valC;
            4'h6: begin
                case (ifun)
                    4'h0: begin
                        valE    = valB + valA;
                        of_next = (valA[63] == valB[63]) && (valE[63] != valB[63]);
                    end
                    4'h1: begin
                        valE    = valB - valA;
                        of_next = (valA[63] != valB[63]) && (valE[63] != valB[63]);
                    end
                    4'h2:    valE = valB & valA;
                    4'h3:    valE = valB ^ valA;
                    default: valE = '0;
                endcase
            end
            4'h8, 4'hA: valE = valB - 64'd8;
            4'h9, 4'hB: valE = valB + 64'd8;
            default: ;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        if ((icode == 4'h2) || (icode == 4'h7)) begin
            case (ifun)
                4'h0:    cond = 1'b1;
                4'h1:    cond = (SF ^ OF) | ZF;
                4'h2:    cond = SF ^ OF;
                4'h3:    cond = ZF;
                4'h4:    cond = !ZF;
                4'h5:    cond = !(SF ^ OF);
                4'h6:    cond = !(SF ^ OF) && !ZF;
                default: cond = 1'b0;
            endcase
        end
    end

    // Only a well-formed OPq may touch the condition codes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ZF <= 1'b0;
            SF <= 1'b0;
            OF <= 1'b0;
        end else if ((icode == 4'h6) && !in_inst && !in_mem) begin
            ZF <= (valE == 64'd0);
            SF <= valE[63];
            OF <= of_next;
        end
    end

endmodule

// File: tb/tb_y86_seq_frontend.sv
// Bench for y86_seq_frontend: directed scenarios with fixed expectations plus randomized fetches
// checked against a cycle-level behavioural model built from byte arrays and wide arithmetic.
module tb_y86_seq_frontend;
    localparam logic [63:0] IDLE = 64'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] PC = IDLE;
    logic        imem_we = 1'b0;
    logic [9:0]  imem_addr = '0;
    logic [7:0]  imem_wdata = '0;
    logic        rf_we = 1'b0;
    logic [3:0]  rf_waddr = '0;
    logic [63:0] rf_wdata = '0;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, valA, valB, valE;
    logic        in_mem, in_inst, hlt, cond, ZF, SF, OF;

    int tests = 0;
    int fails = 0;

    y86_seq_frontend #(.IMEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .in_mem(in_mem), .in_inst(in_inst), .hlt(hlt),
        .valA(valA), .valB(valB), .valE(valE), .cond(cond),
        .ZF(ZF), .SF(SF), .OF(OF)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        imem, iinst, hlt;
    } f_t;

    typedef struct packed {
        logic [63:0] va, vb, ve;
        logic        of, cond;
    } x_t;

    logic [7:0]  m_mem [1024];
    logic [63:0] m_rf  [16];
    logic        m_zf, m_sf, m_of;
    f_t          m_f;

    function automatic logic [63:0] rd(input logic [3:0] i);
        return (i == 4'hF) ? 64'd0 : m_rf[i];
    endfunction

    function automatic f_t fetch_m(input logic [63:0] pc);
        f_t f;
        logic [7:0] b [10];
        int len, off;
        f = '0;
        for (int k = 0; k < 10; k++)
            b[k] = (pc + 64'(k) < 64'd1024) ? m_mem[10'(pc + 64'(k))] : 8'h00;
        f.icode = b[0][7:4];
        f.ifun  = b[0][3:0];
        case (f.icode)
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        off = (f.icode inside {4'h3, 4'h4, 4'h5}) ? 2 : (f.icode inside {4'h7, 4'h8}) ? 1 : 0;
        if (off != 0)
            for (int k = 0; k < 8; k++) f.valc[8*k +: 8] = b[off + k];
        f.ra = (f.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? b[1][7:4] : 4'hF;
        f.rb = (f.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? b[1][3:0] : 4'hF;
        f.iinst = (f.icode > 11) || (f.ifun != 0 && !(f.icode inside {4'h2, 4'h6, 4'h7}))
                || ((f.icode == 2 || f.icode == 7) && f.ifun > 6) || (f.icode == 6 && f.ifun > 3);
        f.imem = (pc + 64'(len) - 64'd1) >= 64'd1024;
        f.valp = (f.iinst || f.imem) ? pc : pc + 64'(len);
        f.hlt  = (f.icode == 0) && !f.iinst && !f.imem;
        return f;
    endfunction

    function automatic x_t exec_m(input f_t f);
        x_t x;
        logic [3:0] sa, sb;
        logic signed [64:0] w;
        logic sl;
        x  = '0;
        sa = 4'hF;
        sb = 4'hF;
        if (f.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = f.ra;
        else if (f.icode inside {4'h9, 4'hB}) sa = 4'h4;
        if (f.icode inside {4'h4, 4'h5, 4'h6}) sb = f.rb;
        else if (f.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'h4;
        x.va = rd(sa);
        x.vb = rd(sb);
        w = '0;
        case (f.icode)
            4'h2: x.ve = x.va;
            4'h3: x.ve = f.valc;
            4'h4, 4'h5: x.ve = x.vb + f.valc;
            4'h6: begin
                if (f.ifun == 0) w = $signed({x.vb[63], x.vb}) + $signed({x.va[63], x.va});
                if (f.ifun == 1) w = $signed({x.vb[63], x.vb}) - $signed({x.va[63], x.va});
                if (f.ifun <= 1) begin
                    x.ve = w[63:0];
                    x.of = (w[64] != w[63]);
                end
                if (f.ifun == 2) x.ve = x.vb & x.va;
                if (f.ifun == 3) x.ve = x.vb ^ x.va;
            end
            4'h8, 4'hA: x.ve = x.vb - 64'd8;
            4'h9, 4'hB: x.ve = x.vb + 64'd8;
            default: ;
        endcase
        sl = m_sf ^ m_of;
        if (f.icode == 2 || f.icode == 7) begin
            case (f.ifun)
                4'h0: x.cond = 1'b1;
                4'h1: x.cond = sl || m_zf;
                4'h2: x.cond = sl;
                4'h3: x.cond = m_zf;
                4'h4: x.cond = !m_zf;
                4'h5: x.cond = !sl;
                4'h6: x.cond = !sl && !m_zf;
                default: x.cond = 1'b0;
            endcase
        end
        return x;
    endfunction

    // Model advances in lock-step with the clock; all updates use pre-edge state
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_rf[i] = '0;
            m_zf = 0; m_sf = 0; m_of = 0;
            m_f = '0;
            m_f.ra = 4'hF;
            m_f.rb = 4'hF;
        end else begin
            f_t nf;
            x_t x;
            x = exec_m(m_f);
            if (m_f.icode == 6 && !m_f.iinst && !m_f.imem) begin
                m_zf = (x.ve == 0);
                m_sf = x.ve[63];
                m_of = x.of;
            end
            nf = fetch_m(PC);
            if (imem_we) m_mem[imem_addr] = imem_wdata;
            if (rf_we && rf_waddr != 4'hF) m_rf[rf_waddr] = rf_wdata;
            m_f = nf;
        end
    end

    // ---------------- stimulus helpers (all start and end at a falling edge) ----------------
    task automatic wr_mem(input int a, input logic [7:0] d);
        imem_we = 1; imem_addr = 10'(a); imem_wdata = d;
        @(negedge clk);
        imem_we = 0;
    endtask

    task automatic wr_reg(input logic [3:0] i, input logic [63:0] v);
        rf_we = 1; rf_waddr = i; rf_wdata = v;
        @(negedge clk);
        rf_we = 0;
    endtask

    task automatic fetch(input logic [63:0] pc);
        PC = pc;
        @(negedge clk);
    endtask

    task automatic idle();
        PC = IDLE;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0;
        #2;
        tests++;
        if ({icode, ifun, rA, rB} !== 16'h00FF) begin fails++; $display("FAIL reset_fields got %h want 00ff", {icode, ifun, rA, rB}); end
        tests++;
        if ({valC, valP, in_mem, in_inst, hlt, ZF, SF, OF} !== '0) begin fails++; $display("FAIL reset_regs got valC=%h valP=%h flags=%b", valC, valP, {in_mem, in_inst, hlt, ZF, SF, OF}); end
        tests++;
        if ({valA, valB, valE, cond} !== '0) begin fails++; $display("FAIL reset_exec got valA=%h valB=%h valE=%h cond=%b", valA, valB, valE, cond); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_irmovq();
        logic [7:0] p [10];
        p = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) wr_mem(i, p[i]);
        fetch(0);
        tests++;
        if ({icode, rA, rB} !== 12'h3F3) begin fails++; $display("FAIL irmovq_fields got %h want 3f3", {icode, rA, rB}); end
        tests++;
        if (valC !== 64'd10 || valP !== 64'd10 || valE !== 64'd10) begin fails++; $display("FAIL irmovq_vals got valC=%0d valP=%0d valE=%0d want 10", valC, valP, valE); end
        idle();
    endtask

    task automatic test_subq_je();
        wr_mem(0, 8'h61); wr_mem(1, 8'h23);
        wr_mem(16, 8'h73);
        for (int i = 17; i < 25; i++) wr_mem(i, 8'(i));
        wr_reg(2, 64'd1); wr_reg(3, 64'd1);
        fetch(0);
        tests++;
        if (valE !== 64'd0) begin fails++; $display("FAIL subq_valE got %h want 0", valE); end
        idle();
        tests++;
        if ({ZF, SF, OF} !== 3'b100) begin fails++; $display("FAIL subq_cc got %b want 100", {ZF, SF, OF}); end
        fetch(16);
        tests++;
        if (cond !== 1'b1 || valP !== 64'd25) begin fails++; $display("FAIL je got cond=%b valP=%0d want 1/25", cond, valP); end
        tests++;
        if (valC !== 64'h1817161514131211) begin fails++; $display("FAIL je_valC got %h want 1817161514131211", valC); end
        idle();
    endtask

    task automatic test_addq();
        wr_mem(0, 8'h60);
        wr_reg(2, 64'd5); wr_reg(3, 64'd7);
        fetch(0);
        tests++;
        if (valA !== 64'd5 || valB !== 64'd7 || valE !== 64'd12) begin fails++; $display("FAIL addq got valA=%0d valB=%0d valE=%0d want 5/7/12", valA, valB, valE); end
        idle();
        tests++;
        if ({ZF, SF, OF} !== 3'b000) begin fails++; $display("FAIL addq_cc got %b want 000", {ZF, SF, OF}); end
    endtask

    task automatic test_overflow();
        wr_reg(2, 64'd1); wr_reg(3, 64'h7FFF_FFFF_FFFF_FFFF);
        fetch(0);
        tests++;
        if (valE !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL ovf_valE got %h want 8000000000000000", valE); end
        idle();
        tests++;
        if ({ZF, SF, OF} !== 3'b011) begin fails++; $display("FAIL ovf_cc got %b want 011", {ZF, SF, OF}); end
    endtask

    task automatic test_errors();
        wr_mem(0, 8'hC0);
        fetch(0);
        tests++;
        if (in_inst !== 1'b1 || valP !== 64'd0 || hlt !== 1'b0) begin fails++; $display("FAIL bad_icode got in_inst=%b valP=%0d hlt=%b want 1/0/0", in_inst, valP, hlt); end
        idle();
        wr_mem(1023, 8'h30);
        fetch(1023);
        tests++;
        if (in_mem !== 1'b1 || valP !== 64'd1023 || in_inst !== 1'b0) begin fails++; $display("FAIL imem_end got in_mem=%b valP=%0d in_inst=%b want 1/1023/0", in_mem, valP, in_inst); end
        idle();
        wr_mem(0, 8'h00);
        fetch(0);
        tests++;
        if (hlt !== 1'b1 || valP !== 64'd1 || {rA, rB} !== 8'hFF) begin fails++; $display("FAIL halt got hlt=%b valP=%0d rArB=%h want 1/1/ff", hlt, valP, {rA, rB}); end
        idle();
    endtask

    task automatic test_same_edge();
        wr_mem(40, 8'h10);
        PC = 40; imem_we = 1; imem_addr = 10'd40; imem_wdata = 8'h00;
        @(negedge clk);
        imem_we = 0;
        tests++;
        if (icode !== 4'h1 || valP !== 64'd41) begin fails++; $display("FAIL same_edge_old got icode=%h valP=%0d want 1/41", icode, valP); end
        @(negedge clk);
        tests++;
        if (hlt !== 1'b1) begin fails++; $display("FAIL same_edge_new got hlt=%b want 1", hlt); end
        idle();
    endtask

    task automatic test_reset_mid();
        wr_mem(0, 8'h60);
        fetch(0);
        #2 rst_n = 0;
        #1;
        tests++;
        if ({icode, rB, valE, valB, ZF, SF, OF} !== {4'h0, 4'hF, 64'd0, 64'd0, 3'b000}) begin fails++; $display("FAIL mid_reset got icode=%h rB=%h valE=%h valB=%h cc=%b", icode, rB, valE, valB, {ZF, SF, OF}); end
        PC = IDLE;
        @(negedge clk);
        rst_n = 1;
        wr_reg(4, 64'd64);
        wr_mem(0, 8'hA0); wr_mem(1, 8'h2F);
        fetch(0);
        tests++;
        if (valE !== 64'd56 || valB !== 64'd64 || valA !== 64'd0) begin fails++; $display("FAIL pushq got valE=%0d valB=%0d valA=%0d want 56/64/0", valE, valB, valA); end
        idle();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int pc;
            logic [7:0] b [10];
            logic [3:0] ic, fn;
            f_t ef;
            x_t ex;
            pc = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 1013)) : int'($urandom_range(1014, 1023));
            ic = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(1, 11));
            if (ic == 2 || ic == 7) fn = 4'($urandom_range(0, 6));
            else if (ic == 6) fn = 4'($urandom_range(0, 3));
            else fn = 4'h0;
            if ($urandom_range(0, 9) == 0) fn = 4'($urandom);
            b[0] = {ic, fn};
            for (int k = 1; k < 10; k++) b[k] = 8'($urandom);
            for (int k = 0; k < 10; k++) if (pc + k < 1024) wr_mem(pc + k, b[k]);
            wr_reg(b[1][7:4], {$urandom, $urandom});
            case ($urandom_range(0, 3))
                0: wr_reg(b[1][3:0], m_rf[b[1][7:4]]);
                1: wr_reg(b[1][3:0], 64'h7FFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 31)));
                default: wr_reg(b[1][3:0], {$urandom, $urandom});
            endcase
            wr_reg(4'h4, {$urandom, $urandom});
            fetch(64'(pc));
            ef = m_f;
            ex = exec_m(m_f);
            tests++;
            if ({icode, ifun, rA, rB} !== {ef.icode, ef.ifun, ef.ra, ef.rb}) begin fails++; $display("FAIL rnd_fields pc=%0d got %h want %h", pc, {icode, ifun, rA, rB}, {ef.icode, ef.ifun, ef.ra, ef.rb}); end
            tests++;
            if (valC !== ef.valc || valP !== ef.valp) begin fails++; $display("FAIL rnd_valCP pc=%0d got %h/%h want %h/%h", pc, valC, valP, ef.valc, ef.valp); end
            tests++;
            if ({in_mem, in_inst, hlt} !== {ef.imem, ef.iinst, ef.hlt}) begin fails++; $display("FAIL rnd_stat pc=%0d got %b want %b", pc, {in_mem, in_inst, hlt}, {ef.imem, ef.iinst, ef.hlt}); end
            tests++;
            if (valA !== ex.va || valB !== ex.vb) begin fails++; $display("FAIL rnd_valAB pc=%0d got %h/%h want %h/%h", pc, valA, valB, ex.va, ex.vb); end
            tests++;
            if (valE !== ex.ve || cond !== ex.cond) begin fails++; $display("FAIL rnd_exec pc=%0d got %h/%b want %h/%b", pc, valE, cond, ex.ve, ex.cond); end
            idle();
            tests++;
            if ({ZF, SF, OF} !== {m_zf, m_sf, m_of}) begin fails++; $display("FAIL rnd_cc pc=%0d got %b want %b", pc, {ZF, SF, OF}, {m_zf, m_sf, m_of}); end
        end
    endtask

    task automatic test_back_to_back();
        // irmovq at 0, OPq at 10, jXX at 12: consecutive fetches with no idle cycle between them
        logic [63:0] pcs [3];
        pcs = '{64'd10, 64'd12, 64'd10};
        for (int i = 0; i < 10; i++) wr_mem(i, (i == 0) ? 8'h30 : 8'($urandom));
        wr_mem(10, 8'h61); wr_mem(11, 8'h12);
        wr_mem(12, 8'h71);
        for (int i = 13; i < 21; i++) wr_mem(i, 8'($urandom));
        wr_reg(1, 64'd3); wr_reg(2, 64'd9);
        for (int i = 0; i < 3; i++) begin
            x_t ex;
            fetch(pcs[i]);
            ex = exec_m(m_f);
            tests++;
            if (valE !== ex.ve || cond !== ex.cond || {ZF, SF, OF} !== {m_zf, m_sf, m_of}) begin fails++; $display("FAIL b2b step=%0d got valE=%h cond=%b cc=%b want %h/%b/%b", i, valE, cond, {ZF, SF, OF}, ex.ve, ex.cond, {m_zf, m_sf, m_of}); end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
        #1;
        test_reset();
        test_irmovq();
        test_subq_je();
        test_addq();
        test_overflow();
        test_errors();
        test_same_edge();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/y86_seq_frontend.md
Y86_SEQ_FRONTEND -- requirements
Module: y86_seq_frontend

Interface
REQ-001 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- PC, in, 64, fetch address.
- imem_we, in, 1, instruction-memory byte write enable.
- imem_addr, in, 10, instruction-memory byte address.
- imem_wdata, in, 8, instruction-memory byte data.
- rf_we, in, 1, register-file write enable (writeback path).
- rf_waddr, in, 4, register-file write index.
- rf_wdata, in, 64, register-file write data.
- icode, out, 4, high nibble of instruction byte 0.
- ifun, out, 4, low nibble of instruction byte 0.
- rA, out, 4, high nibble of instruction byte 1.
- rB, out, 4, low nibble of instruction byte 1.
- valC, out, 64, signed constant word.
- valP, out, 64, next-PC.
- in_mem, out, 1, instruction address error.
- in_inst, out, 1, invalid instruction.
- hlt, out, 1, halt fetched.
- valA, out, 64, signed decode operand A.
- valB, out, 64, signed decode operand B.
- valE, out, 64, signed execute result.
- cond, out, 1, condition result.
- ZF, out, 1, zero flag; SF, out, 1, sign flag; OF, out, 1, overflow flag.
REQ-002 Parameter IMEM_BYTES, default 1024, instruction-memory size in bytes.
REQ-003 One clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 Fetch SHALL register icode/ifun/rA/rB/valC/valP/in_mem/in_inst/hlt on each rising clk from the current PC (1-cycle latency); decode and execute outputs SHALL be combinational from the registered fetch fields, register file and CC.
REQ-005 Instruction lengths: 0 halt, 1 nop, 9 ret = 1 byte; 2 cmovXX, 6 OPq, A pushq, B popq = 2 bytes; 7 jXX, 8 call = 9 bytes; 3 irmovq, 4 rmmovq, 5 mrmovq = 10 bytes; valP = PC + length.
REQ-006 valC SHALL be the little-endian bytes 2..9 for icode 3/4/5, bytes 1..8 for 7/8, else 0; rA=rB=F for instructions without a register byte.
REQ-007 in_inst=1 when icode>B, or ifun nonzero for icode other than 2, 6, 7, or ifun>6 for 2/7, or ifun>3 for 6; in_mem=1 when PC+length-1 >= IMEM_BYTES; on either error valP=PC.
REQ-008 hlt=1 iff icode=0 and no error.
REQ-009 Register file: 15 x 64-bit registers (0-14), index 4 = rsp; reads of index F return 0; rf_we writes on rising clk, and a write to F is ignored.
REQ-010 Decode srcA: rA for icode 2/4/6/A, rsp for 9/B, else none; srcB: rB for 4/5/6, rsp for 8/9/A/B, else none; none gives 0.
REQ-011 valE by icode:
- 2: valA.
- 3: valC.
- 4/5: valB+valC.
- 6: valB op valA, where op is add, sub (valB-valA), and, xor for ifun 0-3.
- 8/A: valB-8.
- 9/B: valB+8.
- else 0.
Arithmetic is 64-bit two's-complement wrap.
REQ-012 CC SHALL update on rising clk only while the registered icode=6 and no error: ZF = (valE==0), SF = valE[63].
- OF for add: operands of equal sign with result sign differing.
- OF for sub: valA and valB signs differ and result sign differs from valB.
- OF for and/xor: 0.
REQ-013 cond for icode 2/7 by ifun: 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; other icodes give cond=0.
REQ-014 Instruction memory is byte-addressed; a write on the same edge as a fetch of that byte returns the old byte.

Reset
REQ-015 rst_n low SHALL immediately clear all registers, ZF/SF/OF, and every registered fetch output to 0, with rF fields = F; instruction memory is not cleared.
REQ-016 After rst_n deasserts, the first rising clk SHALL fetch from PC.

Verification
REQ-017 Memory holds 30 F3 0A 00.. at 0 (irmovq $10,%rbx), PC=0 -> icode=3, rB=3, valC=10, valP=10, valE=10.
REQ-018 r2=5, r3=7 via rf port, then fetch 60 23 (addq) -> valA=5, valB=7, valE=12; next edge ZF=0, SF=0, OF=0.
REQ-019 r2=1, r3=1, fetch 61 23 (subq) -> valE=0; next edge ZF=1, then 73 (je) fetched -> cond=1, valP=PC+9.
REQ-020 r2=1, r3=0x7FFFFFFFFFFFFFFF, addq -> valE=0x8000000000000000, SF=1, OF=1.
REQ-021 Fetch byte C0 -> in_inst=1; PC=IMEM_BYTES-1 with irmovq -> in_mem=1; byte 00 -> hlt=1, valP=PC+1.
REQ-022 rst_n pulsed low mid-run -> outputs and flags 0 asynchronously; pushq with r4=64 afterwards after re-write -> valE=56.
